// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers
// Radix-2 shift-add multiply and restoring divide on magnitudes, followed by one sign-fix cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_launch;
  logic               w_commit;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;
  logic [WIDTH-1:0]   r_araw;
  logic               r_is_div;
  logic               r_dz;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_next   = S_CALC;
        w_launch = !flush;
      end
      S_CALC: if (r_cnt == CW'(WIDTH - 1)) w_next = S_SIGN;
      S_SIGN: begin
        w_next   = S_IDLE;
        w_commit = !flush;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Accumulator layout: multiply {partial product, multiplier}; divide {remainder, dividend}.
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_dsub;
  logic [2*WIDTH-1:0] w_acc_next;
  assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dsub   = w_dshift - {1'b0, r_opd};
  assign w_acc_next = !r_is_div ? {w_madd, r_acc[WIDTH-1:1]} :
                      w_dsub[WIDTH] ? {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                                      {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  assign w_prod    = r_neg_q ? -r_acc : r_acc;
  assign w_quo_mag = r_acc[WIDTH-1:0];
  assign w_rem_mag = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo     = r_neg_q ? -w_quo_mag : w_quo_mag;
  assign w_rem     = r_neg_r ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_araw   <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_launch) begin
        r_cnt    <= '0;
        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
        r_opd    <= op[1] ? w_abs_b : w_abs_a;
        r_araw   <= a;
        r_is_div <= op[1];
        r_dz     <= op[1] && (b == '0);
        r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r  <= w_signed && a[WIDTH-1];
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_next;
      end
      // A concurrent MTHI/MTLO lands now; a launched op overwrites it at commit.
      if (w_commit) begin
        if (!r_is_div)  {r_hi, r_lo} <= w_prod;
        else if (r_dz)  {r_hi, r_lo} <= {r_araw, {WIDTH{1'b1}}};
        else            {r_hi, r_lo} <= {w_rem, w_quo};
      end else if (r_state == S_IDLE && !flush) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the launch edge; returns at the done negedge.
  task automatic wait_done(input string tag, input int exp_busy);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) cnt++;
      @(negedge clk);
    end
    check_eq({tag, "_done"}, 64'(seen), 64'd1);
    check_eq({tag, "_busycyc"}, 64'(cnt), 64'(exp_busy));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    launch(o, x, y);
    wait_done(tag, 33);
    check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    // T1
    run_op("t1_multu", 2'd1, 32'd7, 32'd6, 32'h0, 32'h2A);
    @(negedge clk);
    check_eq("t1_done_pulse", 64'(done), 64'd0);

    // T2, T3 and boundaries
    run_op("t2_mult", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("t3_div", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("t3_divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("ovf_div", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_pos_neg", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_z_signed", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    // T4
    run_op("t4_divu_z", 2'd3, 32'h1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);

    // T5: MTLO in idle
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("t5_mtlo", 64'(lo), 64'hA5A5_A5A5);

    // T5: flush at busy cycle 10
    launch(2'd1, 32'd3, 32'd3);
    repeat (9) @(negedge clk);
    check_eq("t5_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("t5_flush_busy", 64'(busy), 64'd0);
    check_eq("t5_flush_done", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("t5_flush_done2", 64'(done), 64'd0);
    check_eq("t5_flush_lo", 64'(lo), 64'hA5A5_A5A5);
    check_eq("t5_flush_hi", 64'(hi), 64'h0000_1234);

    // T5: MTHI while busy is dropped
    launch(2'd1, 32'd3, 32'd3);
    repeat (2) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("t5_mthi_busy", 64'(hi), 64'h0000_1234);
    wait_done("t5_mul9", 30);
    check_eq("t5_mul9_res", {hi, lo}, 64'd9);

    // T6: async reset at busy cycle 20
    launch(2'd0, 32'd11, 32'd13);
    repeat (19) @(negedge clk);
    check_eq("t6_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 64'(busy), 64'd0);
    check_eq("t6_rst_done", 64'(done), 64'd0);
    check_eq("t6_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T6: back-to-back, second start on the done cycle
    launch(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done("t6_op1", 33);
    check_eq("t6_op1_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check_eq("t6_op2_busy", 64'(busy), 64'd1);
    wait_done("t6_op2", 33);
    check_eq("t6_op2_res", {hi, lo}, {32'd2, 32'd14});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
